lookup_type_pipe: RTL and testbench

Parametrised, pipelined successor to the parser's per-stage type lookup. Matches TYPE_NUM extracted type fields against RULE_NUM ternary rules, with strict priority (lowest index wins) for any RULE_NUM. It returns an opaque RESULT_WIDTH word, which the parser/deparser stage unpacks into type offsets, key offsets and shifts. It adds a valid-qualified pipeline, a programmable default result on miss, per-rule saturating hit counters, and a rule/counter readback port for the control plane.

---
 rtl/lookup_type_pipe_if.sv | 52 +++++
 rtl/lookup_type_pipe.sv | 175 +++++++++++++++++
 tb/tb_lookup_type_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lookup_type_pipe_if.sv
// Lookup request/result, rule configuration and readback signals of lookup_type_pipe.
// The parameters here must match the ones given to the lookup_type_pipe instance.
interface lookup_type_pipe_if #(
  parameter int unsigned RULE_NUM     = 8,
  parameter int unsigned TYPE_NUM     = 2,
  parameter int unsigned TYPE_WIDTH   = 16,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH    = 16
);
  localparam int unsigned ADDR_WIDTH = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
  localparam int unsigned KEY_WIDTH  = TYPE_NUM * TYPE_WIDTH;
  localparam int unsigned RD_WIDTH   = 1 + 2 * KEY_WIDTH + RESULT_WIDTH;

  logic                    i_valid;
  logic [KEY_WIDTH-1:0]    i_type;
  logic                    o_valid;
  logic                    o_hit;
  logic [ADDR_WIDTH-1:0]   o_hit_idx;
  logic [RESULT_WIDTH-1:0] o_result;

  logic                    i_cfg_wren;
  logic                    i_cfg_rden;
  logic [ADDR_WIDTH-1:0]   i_cfg_addr;
  logic                    i_cfg_rule_valid;
  logic [KEY_WIDTH-1:0]    i_cfg_data;
  logic [KEY_WIDTH-1:0]    i_cfg_mask;
  logic [RESULT_WIDTH-1:0] i_cfg_result;
  logic                    i_def_wren;
  logic [RESULT_WIDTH-1:0] i_def_result;
  logic                    i_cnt_clr;
  logic                    o_cfg_rd_valid;
  logic [RD_WIDTH-1:0]     o_cfg_rd_rule;
  logic [CNT_WIDTH-1:0]    o_cfg_rd_cnt;

  modport master (
    output i_valid, i_type,
    output i_cfg_wren, i_cfg_rden, i_cfg_addr, i_cfg_rule_valid,
    output i_cfg_data, i_cfg_mask, i_cfg_result,
    output i_def_wren, i_def_result, i_cnt_clr,
    input  o_valid, o_hit, o_hit_idx, o_result,
    input  o_cfg_rd_valid, o_cfg_rd_rule, o_cfg_rd_cnt
  );

  modport slave (
    input  i_valid, i_type,
    input  i_cfg_wren, i_cfg_rden, i_cfg_addr, i_cfg_rule_valid,
    input  i_cfg_data, i_cfg_mask, i_cfg_result,
    input  i_def_wren, i_def_result, i_cnt_clr,
    output o_valid, o_hit, o_hit_idx, o_result,
    output o_cfg_rd_valid, o_cfg_rd_rule, o_cfg_rd_cnt
  );
endinterface

// File: rtl/lookup_type_pipe.sv
// Pipelined ternary type lookup: lowest-index matching rule wins, default result on miss,
// per-rule saturating hit counters and a registered rule/counter readback port.
module lookup_type_pipe #(
  parameter int unsigned RULE_NUM     = 8,
  parameter int unsigned TYPE_NUM     = 2,
  parameter int unsigned TYPE_WIDTH   = 16,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned LATENCY      = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  lookup_type_pipe_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
  localparam int unsigned KEY_WIDTH  = TYPE_NUM * TYPE_WIDTH;
  localparam int unsigned RD_WIDTH   = 1 + 2 * KEY_WIDTH + RESULT_WIDTH;

  logic [RULE_NUM-1:0]     rule_valid;
  logic [KEY_WIDTH-1:0]    rule_data   [RULE_NUM];
  logic [KEY_WIDTH-1:0]    rule_mask   [RULE_NUM];
  logic [RESULT_WIDTH-1:0] rule_result [RULE_NUM];
  logic [CNT_WIDTH-1:0]    hit_cnt     [RULE_NUM];
  logic [RESULT_WIDTH-1:0] def_result;

  logic [RULE_NUM-1:0]     wr_sel;
  logic [RULE_NUM-1:0]     hit_vec;
  logic                    fin_valid;
  logic [RULE_NUM-1:0]     fin_hit_vec;
  logic                    sel_hit;
  logic [ADDR_WIDTH-1:0]   sel_idx;
  logic [RESULT_WIDTH-1:0] sel_result;
  logic [RD_WIDTH-1:0]     rd_rule;
  logic [CNT_WIDTH-1:0]    rd_cnt;

  // Write decode; an address beyond the last rule selects nothing and is dropped.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < int'(RULE_NUM); i++) begin
      wr_sel[i] = bus.i_cfg_wren && (bus.i_cfg_addr == ADDR_WIDTH'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rule_valid <= '0;
    end else begin
      for (int i = 0; i < int'(RULE_NUM); i++) begin
        if (wr_sel[i]) rule_valid[i] <= bus.i_cfg_rule_valid;
      end
    end
  end

  // Rule payload is qualified by rule_valid, so it carries no reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < int'(RULE_NUM); i++) begin
      if (wr_sel[i]) begin
        rule_data[i]   <= bus.i_cfg_data;
        rule_mask[i]   <= bus.i_cfg_mask;
        rule_result[i] <= bus.i_cfg_result;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      def_result <= '0;
    end else if (bus.i_def_wren) begin
      def_result <= bus.i_def_result;
    end
  end

  // Whole-key compare equals the per-field compare since fields are disjoint slices.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < int'(RULE_NUM); i++) begin
      hit_vec[i] = rule_valid[i] && ((rule_mask[i] & bus.i_type) == rule_data[i]);
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic                s1_valid;
      logic [RULE_NUM-1:0] s1_hit_vec;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          s1_valid   <= 1'b0;
          s1_hit_vec <= '0;
        end else begin
          s1_valid <= bus.i_valid;
          if (bus.i_valid) s1_hit_vec <= hit_vec;
        end
      end

      assign fin_valid   = s1_valid;
      assign fin_hit_vec = s1_hit_vec;
    end else begin : g_lat1
      assign fin_valid   = bus.i_valid;
      assign fin_hit_vec = hit_vec;
    end
  endgenerate

  // Priority select: scanning downward leaves the lowest hit index as the winner.
  always_comb begin
    sel_hit    = |fin_hit_vec;
    sel_idx    = '0;
    sel_result = def_result;
    for (int i = int'(RULE_NUM) - 1; i >= 0; i--) begin
      if (fin_hit_vec[i]) begin
        sel_idx    = ADDR_WIDTH'(i);
        sel_result = rule_result[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_valid   <= 1'b0;
      bus.o_hit     <= 1'b0;
      bus.o_hit_idx <= '0;
      bus.o_result  <= '0;
    end else begin
      bus.o_valid <= fin_valid;
      if (fin_valid) begin
        bus.o_hit     <= sel_hit;
        bus.o_hit_idx <= sel_idx;
        bus.o_result  <= sel_result;
      end
    end
  end

  // Counter update order: global clear, then per-rule rewrite, then saturating increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(RULE_NUM); i++) hit_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(RULE_NUM); i++) begin
        if (bus.i_cnt_clr) begin
          hit_cnt[i] <= '0;
        end else if (wr_sel[i]) begin
          hit_cnt[i] <= '0;
        end else if (fin_valid && sel_hit && (sel_idx == ADDR_WIDTH'(i)) && !(&hit_cnt[i])) begin
          hit_cnt[i] <= hit_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    rd_rule = '0;
    rd_cnt  = '0;
    for (int i = 0; i < int'(RULE_NUM); i++) begin
      if (bus.i_cfg_addr == ADDR_WIDTH'(i)) begin
        rd_rule = {rule_valid[i], rule_data[i], rule_mask[i], rule_result[i]};
        rd_cnt  = hit_cnt[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_cfg_rd_valid <= 1'b0;
      bus.o_cfg_rd_rule  <= '0;
      bus.o_cfg_rd_cnt   <= '0;
    end else begin
      bus.o_cfg_rd_valid <= bus.i_cfg_rden;
      if (bus.i_cfg_rden) begin
        bus.o_cfg_rd_rule <= rd_rule;
        bus.o_cfg_rd_cnt  <= rd_cnt;
      end
    end
  end

endmodule

// File: tb/tb_lookup_type_pipe.sv
// Directed bench: instance A (8 rules, LATENCY=2, 4-bit counters) and instance B
// (17 rules, LATENCY=1); inputs change and outputs are sampled on the falling edge.
module tb_lookup_type_pipe;
  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fails;

  lookup_type_pipe_if #(.RULE_NUM(8),  .TYPE_NUM(2), .TYPE_WIDTH(16), .RESULT_WIDTH(32), .CNT_WIDTH(4))  a_if ();
  lookup_type_pipe_if #(.RULE_NUM(17), .TYPE_NUM(2), .TYPE_WIDTH(16), .RESULT_WIDTH(32), .CNT_WIDTH(16)) b_if ();

  lookup_type_pipe #(
    .RULE_NUM(8), .TYPE_NUM(2), .TYPE_WIDTH(16), .RESULT_WIDTH(32), .CNT_WIDTH(4), .LATENCY(2)
  ) u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (a_if.slave)
  );

  lookup_type_pipe #(
    .RULE_NUM(17), .TYPE_NUM(2), .TYPE_WIDTH(16), .RESULT_WIDTH(32), .CNT_WIDTH(16), .LATENCY(1)
  ) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] key(input logic [15:0] f0, input logic [15:0] f1);
    return {f1, f0};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic h, input logic [2:0] idx, input logic [31:0] res);
    chk({tag, "_valid"}, 128'(a_if.o_valid),   128'(1'b1));
    chk({tag, "_hit"},   128'(a_if.o_hit),     128'(h));
    chk({tag, "_idx"},   128'(a_if.o_hit_idx), 128'(idx));
    chk({tag, "_res"},   128'(a_if.o_result),  128'(res));
  endtask

  task automatic chk_b(input string tag, input logic h, input logic [4:0] idx, input logic [31:0] res);
    chk({tag, "_valid"}, 128'(b_if.o_valid),   128'(1'b1));
    chk({tag, "_hit"},   128'(b_if.o_hit),     128'(h));
    chk({tag, "_idx"},   128'(b_if.o_hit_idx), 128'(idx));
    chk({tag, "_res"},   128'(b_if.o_result),  128'(res));
  endtask

  task automatic idle_all();
    a_if.i_valid = 1'b0; a_if.i_type = '0; a_if.i_cfg_wren = 1'b0; a_if.i_cfg_rden = 1'b0;
    a_if.i_cfg_addr = '0; a_if.i_cfg_rule_valid = 1'b0; a_if.i_cfg_data = '0; a_if.i_cfg_mask = '0;
    a_if.i_cfg_result = '0; a_if.i_def_wren = 1'b0; a_if.i_def_result = '0; a_if.i_cnt_clr = 1'b0;
    b_if.i_valid = 1'b0; b_if.i_type = '0; b_if.i_cfg_wren = 1'b0; b_if.i_cfg_rden = 1'b0;
    b_if.i_cfg_addr = '0; b_if.i_cfg_rule_valid = 1'b0; b_if.i_cfg_data = '0; b_if.i_cfg_mask = '0;
    b_if.i_cfg_result = '0; b_if.i_def_wren = 1'b0; b_if.i_def_result = '0; b_if.i_cnt_clr = 1'b0;
  endtask

  task automatic a_set_rule(input logic [2:0] addr, input logic v, input logic [31:0] d,
                            input logic [31:0] m, input logic [31:0] r);
    a_if.i_cfg_wren = 1'b1; a_if.i_cfg_addr = addr; a_if.i_cfg_rule_valid = v;
    a_if.i_cfg_data = d; a_if.i_cfg_mask = m; a_if.i_cfg_result = r;
  endtask

  task automatic b_write(input logic [4:0] addr, input logic v, input logic [31:0] d,
                         input logic [31:0] m, input logic [31:0] r);
    b_if.i_cfg_wren = 1'b1; b_if.i_cfg_addr = addr; b_if.i_cfg_rule_valid = v;
    b_if.i_cfg_data = d; b_if.i_cfg_mask = m; b_if.i_cfg_result = r;
    tick();
    b_if.i_cfg_wren = 1'b0;
  endtask

  task automatic a_lookup(input logic [31:0] t);
    a_if.i_valid = 1'b1; a_if.i_type = t;
    tick();
    a_if.i_valid = 1'b0;
    chk("a_lat_stage1", 128'(a_if.o_valid), 128'(1'b0));
    tick();
  endtask

  task automatic a_read(input logic [2:0] addr);
    a_if.i_cfg_rden = 1'b1; a_if.i_cfg_addr = addr;
    tick();
    a_if.i_cfg_rden = 1'b0;
  endtask

  task automatic b_read(input logic [4:0] addr);
    b_if.i_cfg_rden = 1'b1; b_if.i_cfg_addr = addr;
    tick();
    b_if.i_cfg_rden = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle_all();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_a_valid",   128'(a_if.o_valid),        128'(1'b0));
    chk("rst_a_hit",     128'(a_if.o_hit),          128'(1'b0));
    chk("rst_a_idx",     128'(a_if.o_hit_idx),      128'(3'd0));
    chk("rst_a_res",     128'(a_if.o_result),       128'(32'h0));
    chk("rst_a_rdvalid", 128'(a_if.o_cfg_rd_valid), 128'(1'b0));
    chk("rst_a_rdrule",  128'(a_if.o_cfg_rd_rule),  128'(97'h0));
    chk("rst_a_rdcnt",   128'(a_if.o_cfg_rd_cnt),   128'(4'h0));
    chk("rst_b_valid",   128'(b_if.o_valid),        128'(1'b0));
    rst_n = 1'b1;
    tick();

    // Lookup with no rules: miss, default result still 0
    a_lookup(key(16'h0800, 16'h0006));
    chk_a("empty", 1'b0, 3'd0, 32'h0000_0000);
    tick();
    chk("empty_pulse", 128'(a_if.o_valid), 128'(1'b0));

    // Rule 3 exact on both fields, rule 5 matches field0 only
    a_set_rule(3'd3, 1'b1, key(16'h0800, 16'h0006), key(16'hFFFF, 16'hFFFF), 32'h1122_3344);
    tick();
    a_set_rule(3'd5, 1'b1, key(16'h0800, 16'h0000), key(16'hFFFF, 16'h0000), 32'hAABB_CCDD);
    tick();
    a_if.i_cfg_wren = 1'b0;
    a_lookup(key(16'h0800, 16'h0006));
    chk_a("prio_r3", 1'b1, 3'd3, 32'h1122_3344);
    a_lookup(key(16'h0800, 16'h0011));
    chk_a("only_r5", 1'b1, 3'd5, 32'hAABB_CCDD);

    // Back-to-back hit, miss, hit with a programmed default
    a_if.i_def_wren = 1'b1; a_if.i_def_result = 32'hDEAD_BEEF;
    tick();
    a_if.i_def_wren = 1'b0;
    a_if.i_valid = 1'b1; a_if.i_type = key(16'h0800, 16'h0006);
    tick();
    a_if.i_type = key(16'h86DD, 16'h0000);
    tick();
    chk_a("b2b_0", 1'b1, 3'd3, 32'h1122_3344);
    a_if.i_type = key(16'h0800, 16'h0011);
    tick();
    chk_a("b2b_1", 1'b0, 3'd0, 32'hDEAD_BEEF);
    a_if.i_valid = 1'b0;
    tick();
    chk_a("b2b_2", 1'b1, 3'd5, 32'hAABB_CCDD);
    tick();
    chk("hold_valid", 128'(a_if.o_valid),   128'(1'b0));
    chk("hold_idx",   128'(a_if.o_hit_idx), 128'(3'd5));
    chk("hold_res",   128'(a_if.o_result),  128'(32'hAABB_CCDD));

    // Invalidate rule 3 in the same cycle as a matching lookup, then look up again
    a_set_rule(3'd3, 1'b0, key(16'h0800, 16'h0006), key(16'hFFFF, 16'hFFFF), 32'h1122_3344);
    a_if.i_valid = 1'b1; a_if.i_type = key(16'h0800, 16'h0006);
    tick();
    a_if.i_cfg_wren = 1'b0;
    tick();
    chk_a("wr_same_old", 1'b1, 3'd3, 32'h1122_3344);
    a_if.i_valid = 1'b0;
    tick();
    chk_a("wr_next_new", 1'b1, 3'd5, 32'hAABB_CCDD);

    // Rule 3 counter: cleared by the rewrite, then +1 from the old-rule hit
    a_read(3'd3);
    chk("rd3_valid", 128'(a_if.o_cfg_rd_valid), 128'(1'b1));
    chk("rd3_rule",  128'(a_if.o_cfg_rd_rule),
        128'({1'b0, key(16'h0800, 16'h0006), key(16'hFFFF, 16'hFFFF), 32'h1122_3344}));
    chk("rd3_cnt",   128'(a_if.o_cfg_rd_cnt),   128'(4'd1));
    tick();
    chk("rd_pulse",  128'(a_if.o_cfg_rd_valid), 128'(1'b0));

    // Read and write of the same rule in one cycle returns the old contents
    a_set_rule(3'd3, 1'b1, key(16'h0800, 16'h0006), key(16'hFFFF, 16'hFFFF), 32'h3333_3333);
    a_read(3'd3);
    a_if.i_cfg_wren = 1'b0;
    chk("rw_old_rule", 128'(a_if.o_cfg_rd_rule),
        128'({1'b0, key(16'h0800, 16'h0006), key(16'hFFFF, 16'hFFFF), 32'h1122_3344}));
    chk("rw_old_cnt",  128'(a_if.o_cfg_rd_cnt), 128'(4'd1));
    a_read(3'd3);
    chk("rw_new_rule", 128'(a_if.o_cfg_rd_rule),
        128'({1'b1, key(16'h0800, 16'h0006), key(16'hFFFF, 16'hFFFF), 32'h3333_3333}));
    chk("rw_new_cnt",  128'(a_if.o_cfg_rd_cnt), 128'(4'd0));

    // Saturation: rule 5 holds 3 hits, 20 more must stop at 0xF
    a_if.i_valid = 1'b1; a_if.i_type = key(16'h0800, 16'h0011);
    repeat (20) tick();
    a_if.i_valid = 1'b0;
    repeat (3) tick();
    a_read(3'd5);
    chk("sat_rule", 128'(a_if.o_cfg_rd_rule),
        128'({1'b1, key(16'h0800, 16'h0000), key(16'hFFFF, 16'h0000), 32'hAABB_CCDD}));
    chk("sat_cnt",  128'(a_if.o_cfg_rd_cnt), 128'(4'hF));

    // Clear coinciding with a counted hit: clear wins
    a_if.i_valid = 1'b1; a_if.i_type = key(16'h0800, 16'h0011);
    tick();
    a_if.i_valid = 1'b0; a_if.i_cnt_clr = 1'b1;
    tick();
    a_if.i_cnt_clr = 1'b0;
    chk_a("clr_hit", 1'b1, 3'd5, 32'hAABB_CCDD);
    a_read(3'd5);
    chk("clr_cnt", 128'(a_if.o_cfg_rd_cnt), 128'(4'd0));

    // Default written alongside a miss lookup applies at its select stage
    a_if.i_def_wren = 1'b1; a_if.i_def_result = 32'h0BAD_F00D;
    a_if.i_valid = 1'b1; a_if.i_type = key(16'h1234, 16'h0000);
    tick();
    a_if.i_def_wren = 1'b0; a_if.i_valid = 1'b0;
    tick();
    chk_a("def_new", 1'b0, 3'd0, 32'h0BAD_F00D);

    // Instance B: rule 16 only; write to out-of-range addr 20 must be dropped
    b_write(5'd16, 1'b1, key(16'h0800, 16'h0006), key(16'hFFFF, 16'hFFFF), 32'hCAFE_F00D);
    b_write(5'd20, 1'b1, key(16'h0800, 16'h0000), key(16'hFFFF, 16'h0000), 32'h1234_5678);
    b_if.i_valid = 1'b1; b_if.i_type = key(16'h0800, 16'h0006);
    tick();
    b_if.i_valid = 1'b0;
    chk_b("b_r16", 1'b1, 5'd16, 32'hCAFE_F00D);
    tick();
    chk("b_pulse", 128'(b_if.o_valid), 128'(1'b0));
    b_if.i_valid = 1'b1; b_if.i_type = key(16'h0800, 16'h0011);
    tick();
    b_if.i_valid = 1'b0;
    chk_b("b_miss", 1'b0, 5'd0, 32'h0000_0000);
    b_read(5'd20);
    chk("b_oor_valid", 128'(b_if.o_cfg_rd_valid), 128'(1'b1));
    chk("b_oor_rule",  128'(b_if.o_cfg_rd_rule),   128'(97'h0));
    chk("b_oor_cnt",   128'(b_if.o_cfg_rd_cnt),    128'(16'h0));
    b_read(5'd16);
    chk("b_rd16_rule", 128'(b_if.o_cfg_rd_rule),
        128'({1'b1, key(16'h0800, 16'h0006), key(16'hFFFF, 16'hFFFF), 32'hCAFE_F00D}));
    chk("b_rd16_cnt",  128'(b_if.o_cfg_rd_cnt), 128'(16'd1));

    // Reset with lookups in flight on both instances
    a_if.i_valid = 1'b1; a_if.i_type = key(16'h0800, 16'h0011);
    b_if.i_valid = 1'b1; b_if.i_type = key(16'h0800, 16'h0006);
    tick();
    #2 rst_n = 1'b0;
    a_if.i_valid = 1'b0; b_if.i_valid = 1'b0;
    #1;
    chk("rst_fly_a0", 128'(a_if.o_valid), 128'(1'b0));
    chk("rst_fly_b0", 128'(b_if.o_valid), 128'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_fly_a1", 128'(a_if.o_valid), 128'(1'b0));
    chk("rst_fly_b1", 128'(b_if.o_valid), 128'(1'b0));
    tick();
    chk("rst_fly_a2", 128'(a_if.o_valid), 128'(1'b0));

    // After reset every rule is invalid and the default is back to 0
    a_lookup(key(16'h0800, 16'h0011));
    chk_a("post_rst", 1'b0, 3'd0, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
